// File: rtl/uart_port_arbiter.sv
// Two-port arbiter sharing one UART buffer controller. RX and TX are arbitrated
// independently with round-robin fairness; each access is a 3-cycle non-blocking poll.
module uart_port_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       p0_rx_req,
    input  logic       p1_rx_req,
    output logic       p0_rx_done,
    output logic       p1_rx_done,
    output logic       p0_rx_hit,
    output logic       p1_rx_hit,
    output logic [7:0] p0_rx_data,
    output logic [7:0] p1_rx_data,
    input  logic       p0_tx_req,
    input  logic       p1_tx_req,
    input  logic [7:0] p0_tx_data,
    input  logic [7:0] p1_tx_data,
    output logic       p0_tx_done,
    output logic       p1_tx_done,
    output logic       p0_tx_hit,
    output logic       p1_tx_hit,
    output logic       uart_out_valid,
    input  logic [7:0] uart_out_data,
    input  logic       uart_out_ready,
    output logic       uart_in_valid,
    output logic [7:0] uart_in_data,
    input  logic       uart_in_ready,
    output logic       rx_owner,
    output logic       tx_owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t     r_rx_state;
    state_t     w_rx_next;
    state_t     r_tx_state;
    state_t     w_tx_next;
    logic       r_rx_last;
    logic       r_rx_owner;
    logic       r_tx_last;
    logic       r_tx_owner;
    logic [7:0] r_tx_byte;
    logic       w_rx_any;
    logic       w_tx_any;
    logic       w_rx_grant;
    logic       w_tx_grant;
    logic       w_rx_wait;
    logic       w_tx_wait;

    // Both requesting: the port that did not win last time; otherwise whoever asks.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

    assign w_rx_any   = p0_rx_req | p1_rx_req;
    assign w_tx_any   = p0_tx_req | p1_tx_req;
    assign w_rx_grant = rr_pick(p0_rx_req, p1_rx_req, r_rx_last);
    assign w_tx_grant = rr_pick(p0_tx_req, p1_tx_req, r_tx_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= S_IDLE;
            r_tx_state <= S_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
            r_tx_state <= w_tx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_last  <= 1'b1;
            r_rx_owner <= 1'b0;
            r_tx_last  <= 1'b1;
            r_tx_owner <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            if (r_rx_state == S_IDLE && w_rx_any) begin
                r_rx_owner <= w_rx_grant;
                r_rx_last  <= w_rx_grant;
            end
            if (r_tx_state == S_IDLE && w_tx_any) begin
                r_tx_owner <= w_tx_grant;
                r_tx_last  <= w_tx_grant;
                r_tx_byte  <= w_tx_grant ? p1_tx_data : p0_tx_data;
            end
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_tx_next = r_tx_state;
        case (r_rx_state)
            S_IDLE:  w_rx_next = w_rx_any ? S_ISSUE : S_IDLE;
            S_ISSUE: w_rx_next = S_WAIT;
            default: w_rx_next = S_IDLE;
        endcase
        case (r_tx_state)
            S_IDLE:  w_tx_next = w_tx_any ? S_ISSUE : S_IDLE;
            S_ISSUE: w_tx_next = S_WAIT;
            default: w_tx_next = S_IDLE;
        endcase
    end

    // A reset landing in WAIT abandons the access, so completion is masked by reset.
    always_comb begin
        w_rx_wait      = (r_rx_state == S_WAIT) && !reset;
        w_tx_wait      = (r_tx_state == S_WAIT) && !reset;
        uart_out_valid = (r_rx_state == S_ISSUE) && !reset;
        uart_in_valid  = (r_tx_state == S_ISSUE) && !reset;
        uart_in_data   = uart_in_valid ? r_tx_byte : 8'h00;
        p0_rx_done     = w_rx_wait && !r_rx_owner;
        p1_rx_done     = w_rx_wait &&  r_rx_owner;
        p0_rx_hit      = p0_rx_done && uart_out_ready;
        p1_rx_hit      = p1_rx_done && uart_out_ready;
        p0_rx_data     = p0_rx_done ? uart_out_data : 8'h00;
        p1_rx_data     = p1_rx_done ? uart_out_data : 8'h00;
        p0_tx_done     = w_tx_wait && !r_tx_owner;
        p1_tx_done     = w_tx_wait &&  r_tx_owner;
        p0_tx_hit      = p0_tx_done && uart_in_ready;
        p1_tx_hit      = p1_tx_done && uart_in_ready;
        rx_owner       = r_rx_owner;
        tx_owner       = r_tx_owner;
    end

endmodule
